frame_bank_scheduler: RTL and testbench
=======================================

# frame_bank_scheduler

Ping-pong frame-buffer scheduler that shares one single-port 8-bit frame RAM between the thermal capture writer and the SPI readout fetcher. It splits the RAM into two banks and steers the writer to one bank and the reader to the other. It swaps the banks on frame boundaries without tearing a frame that is being read out. It arbitrates per-cycle RAM access between the two requesters and flags new and dropped frames to the host side.

## Interface
- `FRAME_BYTES`, 1536, bytes per frame (32x24 pixels x 2 bytes); must be ≤ 8192.
- `hf_clk`  in  1  system clock; all logic is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `wr_frame_start`  in  1  one-cycle pulse: capture begins a frame.
- `wr_frame_done`  in  1  one-cycle pulse: capture finished the frame.
- `wr_req` / `wr_addr` / `wr_data`  in  1 / 13 / 8  write request, with byte offset within the frame and data.
- `wr_ack`  out  1  write granted this cycle.
- `rd_frame_start`  in  1  one-cycle pulse: SPI readout begins (CS asserted, already synchronised to `hf_clk`).
- `rd_frame_end`  in  1  one-cycle pulse: SPI readout ended (CS released).
- `rd_req` / `rd_addr`  in  1 / 13  read request and byte offset.
- `rd_ack`  out  1  read granted this cycle.
- `rd_valid` / `rd_data`  out  1 / 8  read data returned.
- `mem_en` / `mem_we`  out  1 / 1  RAM enable and write enable.
- `mem_addr`  out  14  RAM address `{bank, offset}`.
- `mem_wdata`  out  8  RAM write data.
- `mem_rdata`  in  8  RAM read data; synchronous read, 1-cycle latency.
- `frame_ready`  out  1  a complete, unread frame sits in the read bank.
- `frame_dropped`  out  1  one-cycle pulse: a completed frame was overwritten before it was swapped in.

## Operation
- Registers:
  - `wb`: write bank.
  - `rb`: read bank, always `~wb`.
  - Writer FSM: `W_IDLE` / `W_ACTIVE`.
  - Reader FSM: `R_IDLE` / `R_ACTIVE`.
  - `swap_pending`.
  - `last_grant`: round-robin pointer.
- Writer FSM:
  - `W_IDLE` → `W_ACTIVE` on `wr_frame_start`.
  - `W_ACTIVE` → `W_IDLE` on `wr_frame_done`.
  - `wr_req` is ignored (no ack) in `W_IDLE`.
- Reader FSM:
  - `R_IDLE` → `R_ACTIVE` on `rd_frame_start`; this also clears `frame_ready`.
  - `R_ACTIVE` → `R_IDLE` on `rd_frame_end`.
  - `rd_req` is ignored in `R_IDLE`.
- Swap on `wr_frame_done`:
  - Reader in `R_IDLE`: swap immediately (`wb<=~wb`) and set `frame_ready`.
  - Reader in `R_ACTIVE`: set `swap_pending`.
- On `rd_frame_end` with `swap_pending`: swap, set `frame_ready`, clear `swap_pending`.
- On `wr_frame_start` with `swap_pending` still set: pulse `frame_dropped`, clear `swap_pending`, keep `wb`. The writer overwrites the stale frame.
- Simultaneous events in one cycle:
  - `wr_frame_done` with `rd_frame_end`: treat the reader as idle and swap immediately.
  - `wr_frame_done` with `rd_frame_start`: the reader locks the current `rb`, the swap is deferred (`swap_pending`), and `frame_ready` ends up cleared.
- Arbitration:
  - At most one grant per cycle.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not in `last_grant`.
- Requests are held until acked; `addr`/`data` stay stable while `req` is high.
- Address range rule:
  - Offset ≥ `FRAME_BYTES` on a write: acked but `mem_we=0` (write discarded).
  - Offset ≥ `FRAME_BYTES` on a read: acked, and `rd_data=0x00` on return.
- Reset mid-operation forces all state to reset values immediately. An in-flight read returns no `rd_valid`.

## Timing
- Reset values:
  - `wb=0`, `rb=1`, both FSMs idle, `swap_pending=0`.
  - `last_grant`=write.
  - Outputs `wr_ack`, `rd_ack`, `rd_valid`, `mem_en`, `mem_we`, `frame_ready`, `frame_dropped` = 0.
  - `mem_addr=0`, `mem_wdata=0`, `rd_data=0`.
- `wr_ack`/`rd_ack` and the `mem_*` outputs are combinational from the registered state and the current requests, in the same cycle as the request.
- Read latency:
  - `rd_valid` is high exactly 1 cycle after `rd_ack`.
  - `rd_data = mem_rdata` (or `0x00` for out-of-range offsets) while `rd_valid` is high.
  - Back-to-back reads sustain 1 byte/cycle when the writer is idle.
- Bank, FSM and `frame_ready` changes take effect on the edge after the triggering pulse. A grant in the same cycle as a pulse uses the old bank.

## Configuration
- `FRAME_BANK_READ_PRIORITY_EN` defined:
  - The reader wins every conflict (strict priority) and `last_grant` is unused.
  - Protects SPI readout timing; the writer may stall indefinitely.
- Not defined: round-robin arbitration as described above.

## Test plan
- Idle swap:
  - Stimulus: write frame (bytes 0x01..) with the reader idle, then `wr_frame_done`.
  - Response: `wb=1`, `frame_ready=1`; a subsequent readout returns 0x01,0x02,... from bank 0.
- Deferred swap:
  - Stimulus: `wr_frame_done` during `R_ACTIVE`.
  - Response: no bank change; swap and `frame_ready=1` one edge after `rd_frame_end`.
- Dropped frame:
  - Stimulus: `wr_frame_done` then `wr_frame_start` while the reader stays active.
  - Response: one-cycle `frame_dropped`, `wb` unchanged, `swap_pending=0`.
- Contention:
  - Stimulus: `wr_req` and `rd_req` held high for 4 cycles.
  - Response: grants alternate R,W,R,W (starting R after reset); each `rd_valid` lands 1 cycle after its `rd_ack`.
  - With the macro defined: four consecutive reads, no `wr_ack`.
- Out-of-range:
  - Stimulus: read offset 1536.
  - Response: `rd_data=0x00`.
  - Stimulus: write offset 1600.
  - Response: `wr_ack=1`, `mem_we=0`.
- Async reset:
  - Stimulus: assert `resetn=0` mid-readout with a read outstanding.
  - Response: all outputs at reset values immediately, no `rd_valid` afterwards.

Source files
------------

// File: rtl/frame_bank_scheduler_if.sv
// frame_bank_scheduler_if: writer/reader request ports, frame RAM port and host flags
// for frame_bank_scheduler; slave is the scheduler side, master the surrounding logic.
interface frame_bank_scheduler_if;
    logic        wr_frame_start, wr_frame_done, wr_req, wr_ack;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_frame_start, rd_frame_end, rd_req, rd_ack, rd_valid;
    logic [12:0] rd_addr;
    logic [7:0]  rd_data;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        frame_ready, frame_dropped;
    modport slave (
        input  wr_frame_start, wr_frame_done, wr_req, wr_addr, wr_data,
        input  rd_frame_start, rd_frame_end, rd_req, rd_addr, mem_rdata,
        output wr_ack, rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata,
        output frame_ready, frame_dropped
    );
    modport master (
        output wr_frame_start, wr_frame_done, wr_req, wr_addr, wr_data,
        output rd_frame_start, rd_frame_end, rd_req, rd_addr, mem_rdata,
        input  wr_ack, rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata,
        input  frame_ready, frame_dropped
    );
endinterface

// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler: ping-pong bank steering and per-cycle arbitration of one frame RAM.
// FRAME_BANK_READ_PRIORITY_EN selects strict read priority instead of round-robin.
module frame_bank_scheduler #(
    parameter int FRAME_BYTES = 1536
) (
    input logic hf_clk,
    input logic resetn,
    frame_bank_scheduler_if.slave bus
);
    typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
    typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic wb, wb_next, rb;
    logic swap_pending, swap_pending_next;
    logic frame_ready_q, frame_ready_next;
    logic dropped_q, dropped_next;
    logic rd_valid_q, rd_oor_q;
    logic wr_elig, rd_elig, wr_win, rd_win, wr_in_range, rd_in_range;
    logic r_active, rd_busy, end_swap, swap;
`ifdef FRAME_BANK_READ_PRIORITY_EN
`else
    logic last_grant, last_grant_next;
`endif
    assign rb = ~wb;
    always_comb begin
        w_next = (w_state == W_IDLE) ? (bus.wr_frame_start ? W_ACTIVE : W_IDLE)
                                     : (bus.wr_frame_done ? W_IDLE : W_ACTIVE);
        r_next = (r_state == R_IDLE) ? (bus.rd_frame_start ? R_ACTIVE : R_IDLE)
                                     : (bus.rd_frame_end ? R_IDLE : R_ACTIVE);
        r_active = (r_state == R_ACTIVE);
        // a readout that starts this cycle locks rb; one that ends this cycle frees it
        rd_busy = r_active ? !bus.rd_frame_end : bus.rd_frame_start;
        end_swap = r_active && bus.rd_frame_end && swap_pending;
        swap = (bus.wr_frame_done && !rd_busy) || end_swap;
        dropped_next = bus.wr_frame_start && swap_pending && !(r_active && bus.rd_frame_end);
        swap_pending_next = bus.wr_frame_done ? rd_busy
                          : (dropped_next || (r_active && bus.rd_frame_end)) ? 1'b0 : swap_pending;
        wb_next = wb ^ swap;
        frame_ready_next = swap ? 1'b1 : (!r_active && bus.rd_frame_start) ? 1'b0 : frame_ready_q;
        wr_elig = bus.wr_req && (w_state == W_ACTIVE);
        rd_elig = bus.rd_req && r_active;
`ifdef FRAME_BANK_READ_PRIORITY_EN
        rd_win = rd_elig;
`else
        rd_win = rd_elig && (!wr_elig || !last_grant);
        last_grant_next = rd_win ? 1'b1 : wr_elig ? 1'b0 : last_grant;
`endif
        wr_win = wr_elig && !rd_win;
        wr_in_range = {1'b0, bus.wr_addr} < 14'(FRAME_BYTES);
        rd_in_range = {1'b0, bus.rd_addr} < 14'(FRAME_BYTES);
    end
    assign bus.wr_ack = wr_win;
    assign bus.rd_ack = rd_win;
    assign bus.mem_en = rd_win || (wr_win && wr_in_range);
    assign bus.mem_we = wr_win && wr_in_range;
    assign bus.mem_addr = rd_win ? {rb, bus.rd_addr} : wr_win ? {wb, bus.wr_addr} : 14'd0;
    assign bus.mem_wdata = wr_win ? bus.wr_data : 8'd0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data = (rd_valid_q && !rd_oor_q) ? bus.mem_rdata : 8'd0;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_dropped = dropped_q;
    always_ff @(posedge hf_clk or negedge resetn) begin
        if (!resetn) begin
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            wb            <= 1'b0;
            swap_pending  <= 1'b0;
            frame_ready_q <= 1'b0;
            dropped_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_oor_q      <= 1'b0;
`ifdef FRAME_BANK_READ_PRIORITY_EN
`else
            last_grant    <= 1'b0;
`endif
        end else begin
            w_state       <= w_next;
            r_state       <= r_next;
            wb            <= wb_next;
            swap_pending  <= swap_pending_next;
            frame_ready_q <= frame_ready_next;
            dropped_q     <= dropped_next;
            rd_valid_q    <= rd_win;
            rd_oor_q      <= rd_win && !rd_in_range;
`ifdef FRAME_BANK_READ_PRIORITY_EN
`else
            last_grant    <= last_grant_next;
`endif
        end
    end
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb_frame_bank_scheduler: directed scenarios for frame_bank_scheduler against a
// behavioural single-port RAM; each scenario starts from a fresh reset.
module tb_frame_bank_scheduler;
    logic hf_clk = 1'b0;
    logic resetn = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] ram [0:16383];
    frame_bank_scheduler_if bus();
    frame_bank_scheduler #(.FRAME_BYTES(1536)) dut (.hf_clk(hf_clk), .resetn(resetn), .bus(bus));
    wire [36:0] outs = {bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.mem_en, bus.mem_we, bus.frame_ready,
                        bus.frame_dropped, bus.mem_addr, bus.mem_wdata, bus.rd_data};
    always #5 hf_clk = ~hf_clk;
    always @(posedge hf_clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic tick();
        @(posedge hf_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_frame_start = 0; bus.wr_frame_done = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_frame_start = 0; bus.rd_frame_end = 0; bus.rd_req = 0; bus.rd_addr = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        clear_inputs();
        tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0;
        clear_inputs();
        #1;
        n_checks++; if (outs !== 37'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        n_checks++; if (dut.wb !== 1'b0) begin n_fail++; $display("FAIL reset_wb: got %b want 0", dut.wb); end
        n_checks++; if (dut.swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_swap_pending: got %b want 0", dut.swap_pending); end
        tick();
        resetn = 1;
    endtask

    task automatic test_contention();
        logic [3:0] exp_rd;
        logic prev_rd;
`ifdef FRAME_BANK_READ_PRIORITY_EN
        exp_rd = 4'b1111;
`else
        exp_rd = 4'b0101;
`endif
        do_reset();
        bus.wr_frame_start = 1; bus.rd_frame_start = 1;
        tick();
        bus.wr_frame_start = 0; bus.rd_frame_start = 0;
        bus.wr_req = 1; bus.wr_addr = 13'd10; bus.wr_data = 8'h5A;
        bus.rd_req = 1; bus.rd_addr = 13'd20;
        prev_rd = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.rd_ack !== exp_rd[i]) begin n_fail++; $display("FAIL cont_rd_ack[%0d]: got %b want %b", i, bus.rd_ack, exp_rd[i]); end
            n_checks++; if (bus.wr_ack !== !exp_rd[i]) begin n_fail++; $display("FAIL cont_wr_ack[%0d]: got %b want %b", i, bus.wr_ack, !exp_rd[i]); end
            n_checks++; if (bus.mem_addr !== (exp_rd[i] ? {1'b1, 13'd20} : {1'b0, 13'd10})) begin n_fail++; $display("FAIL cont_mem_addr[%0d]: got %h", i, bus.mem_addr); end
            n_checks++; if (bus.rd_valid !== prev_rd) begin n_fail++; $display("FAIL cont_rd_valid[%0d]: got %b want %b", i, bus.rd_valid, prev_rd); end
            prev_rd = exp_rd[i];
            tick();
        end
        bus.wr_req = 0; bus.rd_req = 0;
        #1;
        n_checks++; if (bus.rd_valid !== exp_rd[3]) begin n_fail++; $display("FAIL cont_rd_valid_last: got %b want %b", bus.rd_valid, exp_rd[3]); end
    endtask

    task automatic test_idle_swap();
        do_reset();
        bus.wr_frame_start = 1;
        tick();
        bus.wr_frame_start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1; bus.wr_addr = 13'(i); bus.wr_data = 8'(i + 1);
            #1;
            n_checks++; if ({bus.wr_ack, bus.mem_we, bus.mem_addr} !== {2'b11, 14'(i)}) begin n_fail++; $display("FAIL idle_write[%0d]: got %b%b %h want 11 %h", i, bus.wr_ack, bus.mem_we, bus.mem_addr, 14'(i)); end
            tick();
        end
        bus.wr_req = 0;
        bus.wr_frame_done = 1;
        #1;
        n_checks++; if (bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_early: got %b want 0", bus.frame_ready); end
        tick();
        bus.wr_frame_done = 0;
        n_checks++; if (bus.frame_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", bus.frame_ready); end
        n_checks++; if (dut.wb !== 1'b1) begin n_fail++; $display("FAIL idle_wb: got %b want 1", dut.wb); end
        bus.rd_frame_start = 1;
        tick();
        bus.rd_frame_start = 0;
        n_checks++; if (bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_clear: got %b want 0", bus.frame_ready); end
        for (int i = 0; i < 5; i++) begin
            bus.rd_req = (i < 4); bus.rd_addr = 13'(i);
            #1;
            if (i < 4) begin
                n_checks++; if ({bus.rd_ack, bus.mem_addr} !== {1'b1, 14'(i)}) begin n_fail++; $display("FAIL idle_read_grant[%0d]: got %b %h want 1 %h", i, bus.rd_ack, bus.mem_addr, 14'(i)); end
            end
            if (i > 0) begin
                n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'(i)}) begin n_fail++; $display("FAIL idle_read_data[%0d]: got %b %h want 1 %h", i, bus.rd_valid, bus.rd_data, 8'(i)); end
            end
            tick();
        end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_read_idle: got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_deferred_swap();
        do_reset();
        bus.rd_frame_start = 1; bus.wr_frame_start = 1;
        tick();
        bus.rd_frame_start = 0; bus.wr_frame_start = 0;
        bus.wr_frame_done = 1;
        tick();
        bus.wr_frame_done = 0;
        n_checks++; if ({dut.wb, dut.swap_pending, bus.frame_ready} !== 3'b010) begin n_fail++; $display("FAIL defer_hold: got %b%b%b want 010", dut.wb, dut.swap_pending, bus.frame_ready); end
        repeat (2) tick();
        bus.rd_frame_end = 1;
        #1;
        n_checks++; if (dut.wb !== 1'b0) begin n_fail++; $display("FAIL defer_wb_early: got %b want 0", dut.wb); end
        tick();
        bus.rd_frame_end = 0;
        n_checks++; if ({dut.wb, dut.swap_pending, bus.frame_ready} !== 3'b101) begin n_fail++; $display("FAIL defer_swap: got %b%b%b want 101", dut.wb, dut.swap_pending, bus.frame_ready); end
    endtask

    task automatic test_dropped();
        do_reset();
        bus.rd_frame_start = 1; bus.wr_frame_start = 1;
        tick();
        bus.rd_frame_start = 0; bus.wr_frame_start = 0;
        bus.wr_frame_done = 1;
        tick();
        bus.wr_frame_done = 0;
        n_checks++; if (bus.frame_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_early: got %b want 0", bus.frame_dropped); end
        bus.wr_frame_start = 1;
        tick();
        bus.wr_frame_start = 0;
        n_checks++; if ({bus.frame_dropped, dut.wb, dut.swap_pending} !== 3'b100) begin n_fail++; $display("FAIL drop_pulse: got %b%b%b want 100", bus.frame_dropped, dut.wb, dut.swap_pending); end
        tick();
        n_checks++; if (bus.frame_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b want 0", bus.frame_dropped); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.wr_frame_start = 1;
        tick();
        bus.wr_frame_start = 0;
        bus.wr_frame_done = 1; bus.rd_frame_start = 1;
        tick();
        bus.wr_frame_done = 0; bus.rd_frame_start = 0;
        n_checks++; if ({dut.wb, dut.swap_pending, bus.frame_ready} !== 3'b010) begin n_fail++; $display("FAIL sim_done_start: got %b%b%b want 010", dut.wb, dut.swap_pending, bus.frame_ready); end
        do_reset();
        bus.wr_frame_start = 1; bus.rd_frame_start = 1;
        tick();
        bus.wr_frame_start = 0; bus.rd_frame_start = 0;
        bus.wr_frame_done = 1; bus.rd_frame_end = 1;
        tick();
        bus.wr_frame_done = 0; bus.rd_frame_end = 0;
        n_checks++; if ({dut.wb, dut.swap_pending, bus.frame_ready} !== 3'b101) begin n_fail++; $display("FAIL sim_done_end: got %b%b%b want 101", dut.wb, dut.swap_pending, bus.frame_ready); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        bus.wr_frame_start = 1; bus.rd_frame_start = 1;
        tick();
        bus.wr_frame_start = 0; bus.rd_frame_start = 0;
        bus.wr_req = 1; bus.wr_addr = 13'd1600; bus.wr_data = 8'h77;
        #1;
        n_checks++; if ({bus.wr_ack, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL oor_write: got %b%b want 10", bus.wr_ack, bus.mem_we); end
        tick();
        bus.wr_addr = 13'd1535; bus.wr_data = 8'hAB;
        #1;
        n_checks++; if ({bus.wr_ack, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL edge_write: got %b%b want 11", bus.wr_ack, bus.mem_we); end
        tick();
        bus.wr_req = 0;
        bus.rd_req = 1; bus.rd_addr = 13'd1536;
        #1;
        n_checks++; if (bus.rd_ack !== 1'b1) begin n_fail++; $display("FAIL oor_read_ack: got %b want 1", bus.rd_ack); end
        tick();
        bus.rd_addr = 13'd1535;
        n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL oor_read_data: got %b %h want 1 00", bus.rd_valid, bus.rd_data); end
        tick();
        bus.rd_req = 0;
        n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL edge_read_data: got %b %h want 1 ff", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.wr_frame_start = 1;
        tick();
        bus.wr_frame_start = 0;
        bus.wr_frame_done = 1;
        tick();
        bus.wr_frame_done = 0;
        bus.rd_frame_start = 1;
        tick();
        bus.rd_frame_start = 0;
        bus.rd_req = 1; bus.rd_addr = 13'd3;
        tick();
        n_checks++; if ({bus.rd_ack, bus.rd_valid} !== 2'b11) begin n_fail++; $display("FAIL arst_pre: got %b%b want 11", bus.rd_ack, bus.rd_valid); end
        #1;
        resetn = 0;
        #1;
        n_checks++; if (outs !== 37'd0) begin n_fail++; $display("FAIL arst_outputs: got %h want 0", outs); end
        n_checks++; if (dut.wb !== 1'b0) begin n_fail++; $display("FAIL arst_wb: got %b want 0", dut.wb); end
        tick();
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_valid: got %b want 0", bus.rd_valid); end
        resetn = 1;
        bus.rd_req = 0;
        tick();
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got %b want 0", bus.rd_valid); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 8'hFF;
        test_reset();
        test_contention();
        test_idle_swap();
        test_deferred_swap();
        test_dropped();
        test_simultaneous();
        test_out_of_range();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
